// File: rtl/lsu_pkg.sv
// Shared types for the data-memory load/store unit.
package lsu_pkg;

  localparam int unsigned LSU_DW = 32;
  localparam int unsigned LSU_AW = 32;

  typedef enum logic [1:0] {
    BYTE    = 2'd0,
    HALF    = 2'd1,
    WORD    = 2'd2,
    ILLEGAL = 2'd3
  } lsu_size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RDATA = 2'd2,
    RESP  = 2'd3
  } lsu_state_e;

  typedef struct packed {
    logic              we;
    lsu_size_e         size;
    logic              is_unsigned;
    logic [LSU_AW-1:0] addr;
    logic [LSU_DW-1:0] wdata;
    logic [4:0]        rd;
  } lsu_req_t;

  typedef struct packed {
    logic              valid;
    logic [LSU_DW-1:0] data;
    logic [4:0]        rd;
    logic              err;
  } lsu_rsp_t;

  // Completion record; error responses always carry zero data.
  function automatic lsu_rsp_t mk_rsp(input logic [LSU_DW-1:0] data,
                                      input logic [4:0]        rd,
                                      input logic              err);
    lsu_rsp_t r;
    r.valid = 1'b1;
    r.data  = err ? '0 : data;
    r.rd    = rd;
    r.err   = err;
    return r;
  endfunction

endpackage

// File: rtl/dmem_lsu_align.sv
// Byte-lane logic: alignment checks, byte enables, store replication and
// load extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  // store / decode side (incoming request)
  input  lsu_size_e          i_size,
  input  logic [1:0]         i_off,
  input  logic [LSU_DW-1:0]  i_wdata,
  output logic               o_illegal,
  output logic               o_misaligned,
  output logic [3:0]         o_be,
  output logic [LSU_DW-1:0]  o_wdata,
  // load side (registered request)
  input  lsu_size_e          i_ld_size,
  input  logic [1:0]         i_ld_off,
  input  logic               i_ld_unsigned,
  input  logic [LSU_DW-1:0]  i_rdata,
  output logic [LSU_DW-1:0]  o_ld_data
);

  logic [LSU_DW-1:0] w_shift;

  // Decode size/offset into error flags, lane enables and replicated data.
  always_comb begin
    o_illegal    = 1'b0;
    o_misaligned = 1'b0;
    o_be         = '0;
    o_wdata      = i_wdata;
    case (i_size)
      BYTE: begin
        o_be    = 4'b0001 << i_off;
        o_wdata = {4{i_wdata[7:0]}};
      end
      HALF: begin
        o_misaligned = i_off[0];
        o_be         = 4'b0011 << i_off;
        o_wdata      = {2{i_wdata[15:0]}};
      end
      WORD: begin
        o_misaligned = (i_off != 2'b00);
        o_be         = 4'b1111;
      end
      default: o_illegal = 1'b1;
    endcase
  end

  assign w_shift = i_rdata >> {i_ld_off, 3'b000};

  // Pick the addressed lanes out of the read word and extend to full width.
  always_comb begin
    o_ld_data = '0;
    case (i_ld_size)
      BYTE:    o_ld_data = i_ld_unsigned ? {24'h0, w_shift[7:0]}
                                         : {{24{w_shift[7]}}, w_shift[7:0]};
      HALF:    o_ld_data = i_ld_unsigned ? {16'h0, w_shift[15:0]}
                                         : {{16{w_shift[15]}}, w_shift[15:0]};
      WORD:    o_ld_data = i_rdata;
      default: o_ld_data = '0;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit: accepts one pipeline access at a time, issues a single
// word-aligned bus transfer, and returns a one-cycle response.
module dmem_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [4:0]            req_rd,
  output logic                  stall_o,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [4:0]            rsp_rd,
  output logic                  rsp_err,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [3:0]            bus_be,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic                  bus_gnt,
  input  logic                  bus_rvalid,
  input  logic [DATA_WIDTH-1:0] bus_rdata
);

  localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e            r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_we;
  lsu_size_e             r_size;
  logic                  r_unsigned;
  logic [1:0]            r_off;
  logic [4:0]            r_rd;
  lsu_rsp_t              r_rsp;
  logic                  r_bus_req;
  logic                  r_bus_we;
  logic [ADDR_WIDTH-1:0] r_bus_addr;
  logic [3:0]            r_bus_be;
  logic [DATA_WIDTH-1:0] r_bus_wdata;

  lsu_req_t              w_req;
  logic                  w_illegal;
  logic                  w_misaligned;
  logic [3:0]            w_be;
  logic [LSU_DW-1:0]     w_wdata;
  logic [LSU_DW-1:0]     w_ld_data;

  // Pack the incoming pipeline request.
  always_comb begin
    w_req.we          = req_we;
    w_req.size        = lsu_size_e'(req_size);
    w_req.is_unsigned = req_unsigned;
    w_req.addr        = LSU_AW'(req_addr);
    w_req.wdata       = LSU_DW'(req_wdata);
    w_req.rd          = req_rd;
  end

  lsu_align u_align (
    .i_size        (w_req.size),
    .i_off         (w_req.addr[1:0]),
    .i_wdata       (w_req.wdata),
    .o_illegal     (w_illegal),
    .o_misaligned  (w_misaligned),
    .o_be          (w_be),
    .o_wdata       (w_wdata),
    .i_ld_size     (r_size),
    .i_ld_off      (r_off),
    .i_ld_unsigned (r_unsigned),
    .i_rdata       (LSU_DW'(bus_rdata)),
    .o_ld_data     (w_ld_data)
  );

  // Access FSM with timeout counter; all bus and response outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_size      <= BYTE;
      r_unsigned  <= 1'b0;
      r_off       <= '0;
      r_rd        <= '0;
      r_rsp       <= '0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_be    <= '0;
      r_bus_wdata <= '0;
    end else begin
      r_rsp.valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_we       <= w_req.we;
            r_size     <= w_req.size;
            r_unsigned <= w_req.is_unsigned;
            r_off      <= w_req.addr[1:0];
            r_rd       <= w_req.rd;
            if (w_illegal || w_misaligned) begin
              r_rsp   <= mk_rsp('0, w_req.rd, 1'b1);
              r_state <= RESP;
            end else begin
              r_cnt       <= '0;
              r_bus_req   <= 1'b1;
              r_bus_we    <= w_req.we;
              r_bus_addr  <= ADDR_WIDTH'({w_req.addr[LSU_AW-1:2], 2'b00});
              r_bus_be    <= w_be;
              r_bus_wdata <= DATA_WIDTH'(w_wdata);
              r_state     <= REQ;
            end
          end
        end
        REQ: begin
          // grant is checked first so it wins over a same-cycle timeout
          if (bus_gnt) begin
            r_bus_req <= 1'b0;
            r_cnt     <= '0;
            if (r_we) begin
              r_rsp   <= mk_rsp('0, r_rd, 1'b0);
              r_state <= RESP;
            end else begin
              r_state <= RDATA;
            end
          end else if (r_cnt == CNT_LAST) begin
            r_bus_req <= 1'b0;
            r_rsp     <= mk_rsp('0, r_rd, 1'b1);
            r_state   <= RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RDATA: begin
          if (bus_rvalid) begin
            r_rsp   <= mk_rsp(w_ld_data, r_rd, 1'b0);
            r_state <= RESP;
          end else if (r_cnt == CNT_LAST) begin
            r_rsp   <= mk_rsp('0, r_rd, 1'b1);
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RESP: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign stall_o   = req_valid & (r_state != RESP);
  assign rsp_valid = r_rsp.valid;
  assign rsp_data  = DATA_WIDTH'(r_rsp.data);
  assign rsp_rd    = r_rsp.rd;
  assign rsp_err   = r_rsp.err;
  assign bus_req   = r_bus_req;
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_be    = r_bus_be;
  assign bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: a vector table of single accesses driven
// through a small bus responder, plus hand sequences for late read data
// and reset during a read.
module tb_dmem_lsu;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        stall_o, rsp_valid, rsp_err;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd;
  logic        bus_req, bus_we, bus_gnt, bus_rvalid;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  dmem_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rd(req_rd), .stall_o(stall_o),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_rd(rsp_rd), .rsp_err(rsp_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata)
  );

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    int          gdel;      // REQ cycles waited before grant (99 = never)
    int          rdel;      // cycles from grant to rvalid (99 = never)
    logic [31:0] rdata;
    int          exp_nreq;  // cycles with bus_req high
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;   // cycle of rsp_valid, accept edge = 0
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; req_rd = '0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'hA5A5_0F0F;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int  nreq;
    int  gcyc;
    bit  done;
    @(negedge clk);
    req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata; req_rd = v.rd;
    bus_gnt = 1'b0; bus_rvalid = 1'b0;
    #1 chk($sformatf("v%0d_stall_c0", idx), {31'b0, stall_o}, 32'd1);
    @(posedge clk);
    nreq = 0; gcyc = -1; done = 0;
    for (int c = 1; c <= 20 && !done; c++) begin
      @(negedge clk);
      if (bus_req) begin
        nreq++;
        chk($sformatf("v%0d_addr", idx), bus_addr, v.exp_addr);
        chk($sformatf("v%0d_be", idx), {28'b0, bus_be}, {28'b0, v.exp_be});
        chk($sformatf("v%0d_we", idx), {31'b0, bus_we}, {31'b0, v.we});
        chk($sformatf("v%0d_wdata", idx), bus_wdata, v.exp_wdata);
      end
      if (rsp_valid) begin
        done = 1;
        chk($sformatf("v%0d_lat", idx), c, v.exp_lat);
        chk($sformatf("v%0d_data", idx), rsp_data, v.exp_data);
        chk($sformatf("v%0d_err", idx), {31'b0, rsp_err}, {31'b0, v.exp_err});
        chk($sformatf("v%0d_rd", idx), {27'b0, rsp_rd}, {27'b0, v.rd});
        chk($sformatf("v%0d_stall_resp", idx), {31'b0, stall_o}, 32'd0);
        chk($sformatf("v%0d_nreq", idx), nreq, v.exp_nreq);
        idle_inputs();
      end else begin
        chk($sformatf("v%0d_stall_wait", idx), {31'b0, stall_o}, 32'd1);
        bus_gnt = bus_req && (nreq - 1 == v.gdel);
        if (bus_gnt) gcyc = c;
        bus_rvalid = (gcyc >= 0) && !v.we && (c == gcyc + v.rdel);
        bus_rdata  = bus_rvalid ? v.rdata : 32'hA5A5_0F0F;
      end
    end
    if (!done) begin
      chk($sformatf("v%0d_rsp_timeout", idx), 32'd0, 32'd1);
      idle_inputs();
    end
    @(negedge clk);
    chk($sformatf("v%0d_single_pulse", idx), {31'b0, rsp_valid}, 32'd0);
    chk($sformatf("v%0d_bus_idle", idx), {31'b0, bus_req}, 32'd0);
  endtask

  initial begin
    //          we  sz uns addr          wdata         rd  gd  rd  rdata         nr addr          be     wdata         data          err lat
    vecs.push_back('{1, 2, 0, 32'h100, 32'hDEADBEEF, 1, 0, 0, 32'h0,        1, 32'h100, 4'hF, 32'hDEADBEEF, 32'h0,        0, 2});
    vecs.push_back('{0, 0, 0, 32'h103, 32'h0,        2, 0, 1, 32'h80FFFFFF, 1, 32'h100, 4'h8, 32'h0,        32'hFFFFFF80, 0, 3});
    vecs.push_back('{0, 0, 1, 32'h103, 32'h0,        3, 0, 1, 32'h80FFFFFF, 1, 32'h100, 4'h8, 32'h0,        32'h00000080, 0, 3});
    vecs.push_back('{1, 1, 0, 32'h202, 32'h00001234, 4, 0, 0, 32'h0,        1, 32'h200, 4'hC, 32'h12341234, 32'h0,        0, 2});
    vecs.push_back('{0, 1, 0, 32'h202, 32'h0,        5, 0, 1, 32'h80015A5A, 1, 32'h200, 4'hC, 32'h0,        32'hFFFF8001, 0, 3});
    vecs.push_back('{0, 2, 0, 32'h101, 32'h0,        6, 0, 1, 32'h0,        0, 32'h0,   4'h0, 32'h0,        32'h0,        1, 1});
    vecs.push_back('{0, 3, 0, 32'h000, 32'h0,        7, 0, 1, 32'h0,        0, 32'h0,   4'h0, 32'h0,        32'h0,        1, 1});
    vecs.push_back('{1, 1, 0, 32'h103, 32'h5555AAAA, 8, 0, 0, 32'h0,        0, 32'h0,   4'h0, 32'h0,        32'h0,        1, 1});
    vecs.push_back('{1, 0, 0, 32'h001, 32'h123456A5, 9, 0, 0, 32'h0,        1, 32'h000, 4'h2, 32'hA5A5A5A5, 32'h0,        0, 2});
    vecs.push_back('{0, 1, 1, 32'h000, 32'h0,       10, 0, 1, 32'h1234F00D, 1, 32'h000, 4'h3, 32'h0,        32'h0000F00D, 0, 3});
    vecs.push_back('{0, 2, 1, 32'h3FC, 32'h0,       11, 2, 3, 32'hCAFEF00D, 3, 32'h3FC, 4'hF, 32'h0,        32'hCAFEF00D, 0, 7});
    vecs.push_back('{0, 0, 0, 32'h102, 32'h0,       12, 0, 1, 32'h007F0000, 1, 32'h100, 4'h4, 32'h0,        32'h0000007F, 0, 3});
    vecs.push_back('{1, 2, 0, 32'h010, 32'h11223344,13, 3, 0, 32'h0,        4, 32'h010, 4'hF, 32'h11223344, 32'h0,        0, 5});
    vecs.push_back('{0, 2, 0, 32'h044, 32'h0,       14, 0, 99,32'h0,        1, 32'h044, 4'hF, 32'h0,        32'h0,        1, 6});
    vecs.push_back('{0, 2, 0, 32'h040, 32'h0,       15, 99,1, 32'h0,        4, 32'h040, 4'hF, 32'h0,        32'h0,        1, 5});

    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bus_req", {31'b0, bus_req}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_bus_be", {28'b0, bus_be}, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_stall", {31'b0, stall_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // read data arriving after the bus timeout must not create a response
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus_rvalid = 1'b1; bus_rdata = 32'h12345678;
      chk($sformatf("late_rvalid_rsp%0d", i), {31'b0, rsp_valid}, 32'd0);
    end
    @(negedge clk);
    bus_rvalid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("late_rvalid_after", {31'b0, rsp_valid}, 32'd0);
    end

    // reset while waiting for read data abandons the access
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h80; req_rd = 5'd7;
    @(posedge clk);
    @(negedge clk);
    chk("rr_bus_req_c1", {31'b0, bus_req}, 32'd1);
    bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0;
    chk("rr_in_rdata", {30'b0, dut.r_state}, {30'b0, RDATA});
    rst = 1'b1; req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("rr_state", {30'b0, dut.r_state}, {30'b0, IDLE});
    chk("rr_bus_req", {31'b0, bus_req}, 32'd0);
    chk("rr_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus_rvalid = 1'b1; bus_rdata = 32'hFEEDFACE;
    @(negedge clk);
    bus_rvalid = 1'b0;
    chk("rr_no_rsp0", {31'b0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk("rr_no_rsp1", {31'b0, rsp_valid}, 32'd0);
    idle_inputs();
    begin
      vec_t v;
      v = '{0, 2, 0, 32'h80, 32'h0, 7, 0, 1, 32'h0BADC0DE, 1, 32'h80, 4'hF, 32'h0, 32'h0BADC0DE, 0, 3};
      run_vec(v, 99);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1);
  end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
Load/store unit between the memory pipeline stage and the external data-memory bus. It takes one load or store per request and produces word-aligned bus transfers with byte enables. Load data is shifted to bit 0 and sign- or zero-extended. It stalls the pipeline until the access completes, and flags misaligned accesses, illegal sizes and bus timeouts as errors.

Parameters:
DATA_WIDTH, 32, data path width; only 32 is supported.
ADDR_WIDTH, 32, byte address width.
TIMEOUT_CYCLES, 255, maximum cycles spent waiting in REQ or RDATA before the access aborts with an error; must be at least 1.

Ports:
clk  in  1  clock; one clock domain.
rst  in  1  synchronous, active-high reset.
req_valid  in  1  memory stage presents an access; held stable while stall_o=1.
req_we  in  1  1=store, 0=load.
req_size  in  2  0=byte, 1=half, 2=word, 3=illegal.
req_unsigned  in  1  zero-extend load data (LBU/LHU).
req_addr  in  ADDR_WIDTH  byte address.
req_wdata  in  DATA_WIDTH  store data, right-aligned.
req_rd  in  5  load destination register, returned with the response.
stall_o  out  1  holds the upstream pipeline.
rsp_valid  out  1  one-cycle completion pulse.
rsp_data  out  DATA_WIDTH  extended load data; 0 for stores and errors.
rsp_rd  out  5  echoed req_rd.
rsp_err  out  1  misaligned access, illegal size, or timeout; valid with rsp_valid.
bus_req  out  1  bus request, registered.
bus_we  out  1  bus write.
bus_addr  out  ADDR_WIDTH  word address, bits [1:0] forced to 0.
bus_be  out  4  byte enables.
bus_wdata  out  DATA_WIDTH  lane-replicated store data.
bus_gnt  in  1  bus accepts the request in this cycle.
bus_rvalid  in  1  read data valid; arrives 1 or more cycles after bus_gnt.
bus_rdata  in  DATA_WIDTH  read data.

Behaviour:
- Reset: state=IDLE, timeout counter=0. All outputs are 0 on the first edge where rst=1. A reset during an access abandons it: bus_req drops and no rsp_valid is produced.
- FSM states: IDLE, REQ, RDATA, RESP.
- IDLE: when req_valid=1, register the request and decode it.
  - Illegal size, or misaligned (half with addr[0]=1, word with addr[1:0]≠0): go to RESP with rsp_err=1. No bus activity.
  - Otherwise: go to REQ.
- REQ: bus_req=1; bus_addr, bus_we, bus_be and bus_wdata come from registers.
  - On bus_gnt: a store goes to RESP, a load goes to RDATA.
  - bus_req is low in the cycle after the grant.
- RDATA: on bus_rvalid, capture the extended data and go to RESP.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. A new request can be accepted in the following IDLE cycle.
- stall_o = req_valid & (state≠RESP). This is combinational, so a presented request stalls in the same cycle.
- Timeout: the counter clears on entry to REQ or RDATA and increments each cycle spent there. When it reaches TIMEOUT_CYCLES, the FSM goes to RESP with rsp_err=1 and bus_req drops. A bus_rvalid that arrives late in IDLE or RESP is ignored.
- If bus_gnt and the timeout hit occur in the same cycle, the grant wins.
- Byte enables: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<addr[1:0]; word = 4'b1111.
- Store data: byte replicated {4{wdata[7:0]}}; half replicated {2{wdata[15:0]}}; word unchanged.
- Load data: shift rdata right by addr[1:0]*8, take 8/16/32 bits, then sign-extend (req_unsigned=0) or zero-extend. Word loads ignore req_unsigned.
- Minimum latency, counting the accept edge as cycle 0:
  - store: rsp_valid in cycle 2.
  - load with rvalid one cycle after gnt: rsp_valid in cycle 3.
  - misaligned or illegal: rsp_valid in cycle 1.
- Bus outputs hold stable while bus_req=1 and bus_gnt=0.

Decomposition:
- Package lsu_pkg:
  - enum lsu_size_e (BYTE, HALF, WORD, ILLEGAL)
  - enum lsu_state_e (IDLE, REQ, RDATA, RESP)
  - struct lsu_req_t (we, size, unsigned, addr, wdata, rd)
  - struct lsu_rsp_t (valid, data, rd, err)
- One combinational sub-module, lsu_align, handles misalignment detection, byte-enable generation, write replication and read extraction/extension. dmem_lsu holds the FSM, timeout counter and registers.

Test Plan:
- Word store, addr=0x100, wdata=0xDEADBEEF, gnt immediate → bus_addr=0x100, bus_be=F, bus_wdata=0xDEADBEEF; rsp_valid in cycle 2 with rsp_err=0; stall_o high in cycles 0-1.
- Signed byte load, addr=0x103, rdata=0x80FFFFFF, rvalid one cycle after gnt → bus_be=8, rsp_data=0xFFFFFF80 in cycle 3; with req_unsigned=1 → 0x00000080.
- Half store, addr=0x202, wdata=0x1234 → bus_be=C, bus_wdata=0x12341234; signed half load of the same location with rdata=0x8001xxxx → rsp_data=0xFFFF8001.
- Misaligned word load, addr=0x101 → bus_req stays 0; rsp_valid and rsp_err=1 in cycle 1; rsp_data=0.
- TIMEOUT_CYCLES=4, bus_gnt held low → bus_req high for 4 cycles then drops; rsp_err=1. A later bus_rvalid is ignored and produces no second rsp_valid.
- rst asserted while in RDATA → bus_req and rsp_valid are 0 after the reset edge, state=IDLE; the next word load completes normally.
